// File: rtl/noc_split_4output.sv
// 1-to-4 packet splitter: a one-entry staging register steers each packet by its
// 2-bit destination field into one of four independent per-port FIFOs.
module noc_split_4output #(
    parameter int WIDTH    = 39,
    parameter int DEST_LSB = 37,
    parameter int DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       fifo_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic             stg_vld;
    logic [WIDTH-1:0] stg_data;
    logic [1:0]       stg_port;

    logic [WIDTH-1:0] mem [4][DEPTH];
    logic [AW-1:0]    wr_ptr [4];
    logic [AW-1:0]    rd_ptr [4];
    logic [AW:0]      cnt [4];

    logic       dispatch;
    logic       in_xfer;
    logic [3:0] push;
    logic [3:0] pop;

    always_comb begin
        fifo_full = '0;
        out_valid = '0;
        for (int k = 0; k < 4; k++) begin
            fifo_full[k] = (cnt[k] == CNT_FULL);
            out_valid[k] = (cnt[k] != '0);
        end
    end

    // Ready depends only on registered state, so no in_data/out_ready -> in_ready path.
    assign dispatch = stg_vld && !fifo_full[stg_port];
    assign in_ready = !stg_vld || !fifo_full[stg_port];
    assign in_xfer  = in_valid && in_ready;
    assign pop      = out_valid & out_ready;

    always_comb begin
        push = '0;
        if (dispatch) push[stg_port] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld  <= 1'b0;
            stg_data <= '0;
            stg_port <= '0;
        end else if (in_xfer) begin
            stg_vld  <= 1'b1;
            stg_data <= in_data;
            stg_port <= in_data[DEST_LSB +: 2];
        end else if (dispatch) begin
            stg_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
                for (int e = 0; e < DEPTH; e++) mem[k][e] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= stg_data;
                    wr_ptr[k]         <= wr_ptr[k] + 1'b1;
                end
                if (pop[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
                case ({push[k], pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + 1'b1;
                    2'b01:   cnt[k] <= cnt[k] - 1'b1;
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    assign out_data0 = mem[0][rd_ptr[0]];
    assign out_data1 = mem[1][rd_ptr[1]];
    assign out_data2 = mem[2][rd_ptr[2]];
    assign out_data3 = mem[3][rd_ptr[3]];

endmodule
